// File: rtl/spd_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spd_mon_pkg
//  Description : Shared types and constants for the speed-vs-reference trend
//                monitor. Holds the FSM state encoding, the two check modes
//                and a small deadband helper. The snapshot record depends on
//                the monitor's width parameters and is declared inside the
//                monitor itself.
//  Revision    : 1.0  initial release
// ============================================================================
package spd_mon_pkg;

  // Check sequencer states
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_COMPARE = 2'd3
  } state_t;

  // Check modes
  localparam int MODE_COMMON = 0;  // every channel follows the reference trend
  localparam int MODE_DIFF   = 1;  // sign of (ch0 - ch1) follows ref - CTR

  // True when val lies inside the closed band [-band, +band]
  function automatic logic in_band(input int val, input int band);
    return (val <= band) && (val >= -band);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spd_hist_ring.sv
`default_nettype none
// ============================================================================
//  Module      : spd_hist_ring
//  Description : DEPTH-entry snapshot history ring with a single write
//                pointer. The entry at the write pointer is the oldest one,
//                so rd_data presents the snapshot taken DEPTH writes ago; the
//                caller registers it on the same edge that overwrites it
//                (read-before-write). A fill counter saturates at DEPTH.
//  Ports       : clk      in   system clock
//                RST_n    in   asynchronous active-low reset
//                clr      in   synchronous clear of pointer and fill count
//                wr_en    in   store wr_data at the write pointer
//                wr_data  in   snapshot to store
//                rd_data  out  oldest snapshot (slot about to be overwritten)
//                full     out  ring holds DEPTH snapshots
//  Revision    : 1.0  initial release
// ============================================================================
module spd_hist_ring #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             RST_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [FW-1:0]    r_fill;

  assign rd_data = r_mem[r_wr_ptr];
  assign full    = (r_fill == FW'(DEPTH));

  // DEPTH is a power of two, so the pointer wraps naturally
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      r_wr_ptr <= '0;
      r_fill   <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_fill   <= '0;
    end else if (wr_en) begin
      r_wr_ptr <= r_wr_ptr + PW'(1);
      if (!full) begin
        r_fill <= r_fill + FW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read once the fill count says
  // they were written.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spd_trend_mon.sv
`default_nettype none
// ============================================================================
//  Module      : spd_trend_mon
//  Description : Speed-vs-reference trend monitor. On sample_vld it waits
//                SETTLE cycles, snapshots {ref_in, chan_in} into a history
//                ring and compares against the snapshot DEPTH samples older
//                (MODE_COMMON) or checks the current ch0/ch1 split against the
//                reference offset from CTR (MODE_DIFF). Results are held
//                until the next check or a clear.
//  Ports       : clk        in   system clock
//                RST_n      in   asynchronous active-low reset
//                clr        in   sync clear of history, counters and flags
//                sample_vld in   request a check of the current values
//                ref_in     in   reference (signed; unsigned in MODE_DIFF)
//                chan_in    in   NCH packed signed channels, ch0 in LSBs
//                chk_done   out  1-cycle pulse: check finished
//                chk_skip   out  history not full or inside deadband
//                chk_pass   out  no channel error and not skipped
//                err_chan   out  per-channel failure flags
//                err_cnt    out  saturating count of failed checks
//                hist_full  out  ring holds >= DEPTH snapshots
//  Revision    : 1.0  initial release
// ============================================================================
module spd_trend_mon
  import spd_mon_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int DW     = 12,
  parameter int RW     = 16,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 100,
  parameter int DBAND  = 16,
  parameter int MODE   = 0,
  parameter int CTR    = 'h800
) (
  input  logic              clk,
  input  logic              RST_n,
  input  logic              clr,
  input  logic              sample_vld,
  input  logic [RW-1:0]     ref_in,
  input  logic [NCH*DW-1:0] chan_in,
  output logic              chk_done,
  output logic              chk_skip,
  output logic              chk_pass,
  output logic [NCH-1:0]    err_chan,
  output logic [7:0]        err_cnt,
  output logic              hist_full
);

  localparam int CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int C_HI = CTR + DBAND;
  localparam int C_LO = CTR - DBAND;
  localparam int C1   = (NCH > 1) ? 1 : 0;

  typedef struct packed {
    logic signed [RW-1:0] ref_v;
    logic [NCH*DW-1:0]    chan;
  } snap_t;

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_capture;
  logic          w_compare;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_compare   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (sample_vld) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = '0;
        end
      end
      S_SETTLE: begin
        // A new request while settling restarts the settle window
        if (sample_vld) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CW'(SETTLE - 1)) begin
          w_state_nxt = S_CAPTURE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        w_compare   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // History ring and snapshot registers
  // --------------------------------------------------------------------------
  snap_t w_wr_snap;
  snap_t w_rd_snap;
  logic  w_ring_full;
  snap_t r_cur;
  snap_t r_old;
  logic  r_full_before;

  assign w_wr_snap.ref_v = ref_in;
  assign w_wr_snap.chan  = chan_in;

  spd_hist_ring #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(snap_t))
  ) u_ring (
    .clk     (clk),
    .RST_n   (RST_n),
    .clr     (clr),
    .wr_en   (w_capture & ~clr),
    .wr_data (w_wr_snap),
    .rd_data (w_rd_snap),
    .full    (w_ring_full)
  );

  // The old entry and the pre-write fill state are latched on the same edge
  // that overwrites the slot.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      r_cur         <= '0;
      r_old         <= '0;
      r_full_before <= 1'b0;
    end else if (clr) begin
      r_cur         <= '0;
      r_old         <= '0;
      r_full_before <= 1'b0;
    end else if (w_capture) begin
      r_cur         <= w_wr_snap;
      r_old         <= w_rd_snap;
      r_full_before <= w_ring_full;
    end
  end

  // --------------------------------------------------------------------------
  // Comparators
  // --------------------------------------------------------------------------
  logic signed [RW:0] w_dref;
  logic [NCH-1:0]     w_err_common;

  // One extra bit keeps the difference of two full-scale values exact
  assign w_dref = (RW+1)'(r_cur.ref_v) - (RW+1)'(r_old.ref_v);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic signed [DW-1:0] w_cur_ch;
    logic signed [DW-1:0] w_old_ch;
    logic signed [DW:0]   w_dch;
    logic                 w_dch_pos;
    logic                 w_dch_neg;

    assign w_cur_ch  = r_cur.chan[i*DW +: DW];
    assign w_old_ch  = r_old.chan[i*DW +: DW];
    assign w_dch     = (DW+1)'(w_cur_ch) - (DW+1)'(w_old_ch);
    assign w_dch_neg = w_dch[DW];
    assign w_dch_pos = ~w_dch[DW] & (w_dch != '0);

    // Only meaningful outside the deadband, where dref is never zero
    assign w_err_common[i] = w_dref[RW] ? ~w_dch_neg : ~w_dch_pos;
  end

  logic signed [DW-1:0] w_ch0;
  logic signed [DW-1:0] w_ch1;
  logic signed [DW:0]   w_split;
  int                   w_ref_u;
  logic                 w_err_split;
  logic                 w_skip;
  logic [NCH-1:0]       w_err;

  assign w_ch0   = r_cur.chan[0 +: DW];
  assign w_ch1   = r_cur.chan[C1*DW +: DW];
  assign w_split = (DW+1)'(w_ch0) - (DW+1)'(w_ch1);
  assign w_ref_u = int'({1'b0, r_cur.ref_v});

  always_comb begin
    w_err_split = 1'b0;
    if (w_ref_u > C_HI) begin
      w_err_split = ~(~w_split[DW] & (w_split != '0));
    end else if (w_ref_u < C_LO) begin
      w_err_split = ~w_split[DW];
    end else begin
      w_err_split = ~in_band(int'(w_split), DBAND);
    end
  end

  always_comb begin
    w_skip = 1'b0;
    w_err  = '0;
    if (MODE == MODE_DIFF) begin
      w_err[0] = w_err_split;
    end else begin
      w_skip = ~r_full_before | in_band(int'(w_dref), DBAND);
      w_err  = w_skip ? '0 : w_err_common;
    end
  end

  // --------------------------------------------------------------------------
  // Result registers
  // --------------------------------------------------------------------------
  logic           r_done;
  logic           r_skip;
  logic           r_pass;
  logic [NCH-1:0] r_err;
  logic [7:0]     r_err_cnt;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      r_done    <= 1'b0;
      r_skip    <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= '0;
      r_err_cnt <= '0;
    end else if (clr) begin
      r_done    <= 1'b0;
      r_skip    <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= '0;
      r_err_cnt <= '0;
    end else begin
      r_done <= w_compare;
      if (w_compare) begin
        r_skip <= w_skip;
        r_err  <= w_err;
        r_pass <= ~w_skip & ~(|w_err);
        if (!w_skip && (|w_err) && (r_err_cnt != 8'hFF)) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end
    end
  end

  assign chk_done  = r_done;
  assign chk_skip  = r_skip;
  assign chk_pass  = r_pass;
  assign err_chan  = r_err;
  assign err_cnt   = r_err_cnt;
  assign hist_full = w_ring_full;

endmodule
`default_nettype wire

// File: tb/tb_spd_trend_mon.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spd_trend_mon
//  Description : Self-checking bench for spd_trend_mon. One instance runs in
//                common-trend mode against a scoreboard fed by a reference
//                model; a second instance runs in differential mode.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spd_trend_mon;

  localparam int SETTLE = 20;
  localparam int DEPTH  = 4;
  localparam int DBAND  = 16;
  localparam int LIMIT  = SETTLE + 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;

  logic        sv0 = 1'b0;
  logic [15:0] ref0 = '0;
  logic [23:0] chan0 = '0;
  logic        done0, skip0, pass0, full0;
  logic [1:0]  err0;
  logic [7:0]  cnt0;

  logic        sv1 = 1'b0;
  logic [15:0] ref1 = '0;
  logic [23:0] chan1 = '0;
  logic        done1, skip1, pass1, full1;
  logic [1:0]  err1;
  logic [7:0]  cnt1;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  spd_trend_mon #(
    .NCH(2), .DW(12), .RW(16), .DEPTH(DEPTH), .SETTLE(SETTLE),
    .DBAND(DBAND), .MODE(0), .CTR('h800)
  ) u_com (
    .clk(clk), .RST_n(rst_n), .clr(clr), .sample_vld(sv0),
    .ref_in(ref0), .chan_in(chan0),
    .chk_done(done0), .chk_skip(skip0), .chk_pass(pass0),
    .err_chan(err0), .err_cnt(cnt0), .hist_full(full0)
  );

  spd_trend_mon #(
    .NCH(2), .DW(12), .RW(16), .DEPTH(DEPTH), .SETTLE(SETTLE),
    .DBAND(DBAND), .MODE(1), .CTR('h800)
  ) u_dif (
    .clk(clk), .RST_n(rst_n), .clr(clr), .sample_vld(sv1),
    .ref_in(ref1), .chan_in(chan1),
    .chk_done(done1), .chk_skip(skip1), .chk_pass(pass1),
    .err_chan(err1), .err_cnt(cnt1), .hist_full(full1)
  );

  // --------------------------------------------------------------------------
  // Reference model and scoreboard for the common-trend instance
  // --------------------------------------------------------------------------
  typedef struct {
    logic       skip;
    logic       pass;
    logic [1:0] err;
    logic [7:0] cnt;
    logic       full;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   m_ref[$];
  int   m_c0[$];
  int   m_c1[$];
  int   m_errcnt = 0;

  task automatic model_clear();
    m_ref.delete();
    m_c0.delete();
    m_c1.delete();
    m_errcnt = 0;
  endtask

  task automatic model_push(input int r, input int c0, input int c1);
    exp_t e;
    int   dr, d0, d1;
    e.skip = 1'b1;
    e.err  = 2'b00;
    if (m_ref.size() == DEPTH) begin
      dr = r - m_ref[0];
      d0 = c0 - m_c0[0];
      d1 = c1 - m_c1[0];
      if (dr > DBAND || dr < -DBAND) begin
        e.skip = 1'b0;
        if (dr > 0) begin
          e.err[0] = !(d0 > 0);
          e.err[1] = !(d1 > 0);
        end else begin
          e.err[0] = !(d0 < 0);
          e.err[1] = !(d1 < 0);
        end
      end
    end
    m_ref.push_back(r);
    m_c0.push_back(c0);
    m_c1.push_back(c1);
    if (m_ref.size() > DEPTH) begin
      void'(m_ref.pop_front());
      void'(m_c0.pop_front());
      void'(m_c1.pop_front());
    end
    e.pass = !e.skip && (e.err == 2'b00);
    if (!e.skip && e.err != 2'b00 && m_errcnt < 255) m_errcnt++;
    e.cnt  = 8'(m_errcnt);
    e.full = (m_ref.size() == DEPTH);
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (done0) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL sb_unexpected_done: chk_done=1 required none at %0t", $time);
      end else begin
        sb_e = sb_q.pop_front();
        n_vec += 5;
        if (skip0 !== sb_e.skip) begin
          n_miss++;
          $display("FAIL sb_skip: got %b expected %b at %0t", skip0, sb_e.skip, $time);
        end
        if (pass0 !== sb_e.pass) begin
          n_miss++;
          $display("FAIL sb_pass: got %b expected %b at %0t", pass0, sb_e.pass, $time);
        end
        if (err0 !== sb_e.err) begin
          n_miss++;
          $display("FAIL sb_err_chan: got %b expected %b at %0t", err0, sb_e.err, $time);
        end
        if (cnt0 !== sb_e.cnt) begin
          n_miss++;
          $display("FAIL sb_err_cnt: got %0d expected %0d at %0t", cnt0, sb_e.cnt, $time);
        end
        if (full0 !== sb_e.full) begin
          n_miss++;
          $display("FAIL sb_hist_full: got %b expected %b at %0t", full0, sb_e.full, $time);
        end
      end
    end
  end

  // Pulse sample_vld on u_com, log the expectation, wait for chk_done.
  // lat = edges from the sampling edge to chk_done, or -1 on timeout.
  task automatic sample0(input int r, input int c0, input int c1, output int lat);
    @(negedge clk);
    ref0  = 16'(r);
    chan0 = {12'(c1), 12'(c0)};
    sv0   = 1'b1;
    model_push(r, c0, c1);
    @(negedge clk);
    sv0 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done0 && lat < LIMIT);
    if (!done0) lat = -1;
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({done0, skip0, pass0, err0, cnt0, full0} !== 14'd0) begin
      n_miss++;
      $display("FAIL reset_com: got %b expected 0", {done0, skip0, pass0, err0, cnt0, full0});
    end
    n_vec++;
    if ({done1, skip1, pass1, err1, cnt1, full1} !== 14'd0) begin
      n_miss++;
      $display("FAIL reset_dif: got %b expected 0", {done1, skip1, pass1, err1, cnt1, full1});
    end
  endtask

  task automatic test_fill();
    int lat;
    for (int k = 0; k < DEPTH; k++) begin
      sample0(0, 0, 0, lat);
      n_vec++;
      if (lat < 0) begin
        n_miss++;
        $display("FAIL fill_timeout: no chk_done on sample %0d", k);
      end
      n_vec++;
      if (full0 !== (k == DEPTH - 1)) begin
        n_miss++;
        $display("FAIL fill_hist_full: sample %0d got %b expected %b", k, full0, (k == DEPTH - 1));
      end
    end
  endtask

  task automatic test_lean_up();
    int lat;
    sample0(400, 50, 50, lat);
    n_vec++;
    if (lat !== SETTLE + 2) begin
      n_miss++;
      $display("FAIL lean_up_latency: got %0d expected %0d", lat, SETTLE + 2);
    end
    n_vec++;
    if (pass0 !== 1'b1 || err0 !== 2'b00) begin
      n_miss++;
      $display("FAIL lean_up_pass: got pass=%b err=%b expected pass=1 err=00", pass0, err0);
    end
  endtask

  task automatic test_fault();
    int lat;
    sample0(400, 50, 0, lat);
    n_vec++;
    if (lat < 0 || err0 !== 2'b10 || pass0 !== 1'b0 || cnt0 !== 8'd1) begin
      n_miss++;
      $display("FAIL fault_ch1: lat=%0d err=%b pass=%b cnt=%0d expected err=10 pass=0 cnt=1",
               lat, err0, pass0, cnt0);
    end
    for (int i = 0; i < 300; i++) begin
      sample0(500 + 100 * i, 0, 0, lat);
      if (lat < 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL fault_timeout: no chk_done on failure %0d", i);
      end
    end
    n_vec++;
    if (cnt0 !== 8'd255) begin
      n_miss++;
      $display("FAIL fault_saturate: got %0d expected 255", cnt0);
    end
  endtask

  task automatic test_deadband();
    int lat;
    sample0(m_ref[0] + 10, -100, -100, lat);
    n_vec++;
    if (lat < 0 || skip0 !== 1'b1 || err0 !== 2'b00) begin
      n_miss++;
      $display("FAIL deadband: lat=%0d skip=%b err=%b expected skip=1 err=00", lat, skip0, err0);
    end
  endtask

  task automatic test_lean_down();
    int lat;
    sample0(m_ref[0] - 400, m_c0[0] - 30, m_c1[0] - 30, lat);
    n_vec++;
    if (lat < 0 || pass0 !== 1'b1 || skip0 !== 1'b0) begin
      n_miss++;
      $display("FAIL lean_down: lat=%0d pass=%b skip=%b expected pass=1 skip=0", lat, pass0, skip0);
    end
  endtask

  task automatic test_mode_diff();
    int         refs[3]  = '{'h600, 'h800, 'hA00};
    int         c0s[3]   = '{100, 150, 100};
    int         c1s[3]   = '{200, 150, 200};
    logic       epass[3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0] eerr[3]  = '{2'b00, 2'b00, 2'b01};
    logic [7:0] ecnt[3]  = '{8'd0, 8'd0, 8'd1};
    int         n;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ref1  = 16'(refs[k]);
      chan1 = {12'(c1s[k]), 12'(c0s[k])};
      sv1   = 1'b1;
      @(negedge clk);
      sv1 = 1'b0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done1 && n < LIMIT);
      n_vec++;
      if (!done1 || pass1 !== epass[k] || err1 !== eerr[k] || skip1 !== 1'b0 || cnt1 !== ecnt[k]) begin
        n_miss++;
        $display("FAIL mode_diff_%0d: done=%b pass=%b err=%b skip=%b cnt=%0d expected pass=%b err=%b skip=0 cnt=%0d",
                 k, done1, pass1, err1, skip1, cnt1, epass[k], eerr[k], ecnt[k]);
      end
    end
  endtask

  task automatic test_retrigger();
    int lat;
    int r, c0, c1;
    r  = m_ref[0] + 400;
    c0 = m_c0[0] + 20;
    c1 = m_c1[0] + 20;
    @(negedge clk);
    ref0  = 16'(r);
    chan0 = {12'(c1), 12'(c0)};
    sv0   = 1'b1;
    @(negedge clk);
    sv0 = 1'b0;
    repeat (SETTLE / 2) @(negedge clk);
    sample0(r, c0, c1, lat);
    n_vec++;
    if (lat !== SETTLE + 2) begin
      n_miss++;
      $display("FAIL retrigger_latency: got %0d expected %0d", lat, SETTLE + 2);
    end
    n_vec++;
    if (pass0 !== 1'b1) begin
      n_miss++;
      $display("FAIL retrigger_pass: got %b expected 1", pass0);
    end
  endtask

  task automatic test_clear();
    int ndone = 0;
    @(negedge clk);
    clr = 1'b1;
    sv0 = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    sv0 = 1'b0;
    model_clear();
    n_vec++;
    if ({done0, skip0, pass0, err0, cnt0, full0} !== 14'd0) begin
      n_miss++;
      $display("FAIL clear_state: got %b expected 0", {done0, skip0, pass0, err0, cnt0, full0});
    end
    repeat (SETTLE + 10) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    n_vec++;
    if (ndone !== 0) begin
      n_miss++;
      $display("FAIL clear_drops_sample: got %0d chk_done expected 0", ndone);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int ndone = 0;
    sample0(300, 10, 10, lat);
    @(negedge clk);
    ref0 = 16'd900;
    sv0  = 1'b1;
    @(negedge clk);
    sv0 = 1'b0;
    repeat (SETTLE / 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({done0, skip0, pass0, err0, cnt0, full0} !== 14'd0) begin
      n_miss++;
      $display("FAIL reset_mid_state: got %b expected 0", {done0, skip0, pass0, err0, cnt0, full0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    repeat (SETTLE + 10) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    n_vec++;
    if (ndone !== 0 || full0 !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_mid_abort: got %0d chk_done full=%b expected 0 and 0", ndone, full0);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_lean_up();
    test_fault();
    test_deadband();
    test_lean_down();
    test_mode_diff();
    test_retrigger();
    test_clear();
    test_reset_mid();
    n_vec++;
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
